// File: rtl/result_capture_pkg.sv
// Shared types and default sizing for the result_capture block.
package result_capture_pkg;

  localparam int DEPTH_DEF = 8;
  localparam int NSAMP_DEF = 16;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } state_e;

endpackage

// File: rtl/result_capture_fifo.sv
// result_fifo: synchronous FIFO with wrap-bit pointers; the head is read combinationally.
module result_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [WIDTH-1:0]         head_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic             do_push, do_pop;

  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty_o = (wr_q == rd_q);
  assign head_o  = mem_q[rd_q[AW-1:0]];
  assign count_o = wr_q - rd_q;

  // A push into a full FIFO is only legal when the head leaves on the same edge.
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + (AW + 1)'(1);
    if (do_pop)  rd_d = rd_q + (AW + 1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/result_capture.sv
// result_capture: runs of NSAMP {f1,f2} samples are queued for a consumer while f2 statistics accumulate.
// Defining RESULT_CAPTURE_EDGE_EN adds the edge_count port and its f2 rising-edge counter.
module result_capture
  import result_capture_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int NSAMP = NSAMP_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic             f1,
  input  logic             f2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_data,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] f2_count,
  output logic             overflow
`ifdef RESULT_CAPTURE_EDGE_EN
  ,
  output logic [CNT_W-1:0] edge_count
`endif
);

  localparam int               AW        = $clog2(DEPTH);
  localparam logic [7:0]       LAST_SAMP = 8'(NSAMP - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_e           state_q, state_d;
  logic [7:0]       samp_q, samp_d;
  logic [CNT_W-1:0] f2cnt_q, f2cnt_d;
  logic             ovf_q, ovf_d;
`ifdef RESULT_CAPTURE_EDGE_EN
  logic             prev_q, prev_d;
  logic [CNT_W-1:0] edge_q, edge_d;
`endif

  logic             sample, push, pop, full, empty;
  logic [1:0]       head;
  logic [AW:0]      count;

  assign pop    = out_valid && out_ready;
  assign sample = (state_q == CAPTURE) && in_valid;
  assign push   = sample && (!full || pop);

  result_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(2)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (push),
    .pop_i  (pop),
    .data_i ({f1, f2}),
    .full_o (full),
    .empty_o(empty),
    .head_o (head),
    .count_o(count)
  );

  always_comb begin
    state_d = state_q;
    samp_d  = samp_q;
    f2cnt_d = f2cnt_q;
    ovf_d   = ovf_q;
`ifdef RESULT_CAPTURE_EDGE_EN
    prev_d  = prev_q;
    edge_d  = edge_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CAPTURE;
          samp_d  = '0;
          f2cnt_d = '0;
          ovf_d   = 1'b0;
`ifdef RESULT_CAPTURE_EDGE_EN
          prev_d  = 1'b0;
          edge_d  = '0;
`endif
        end
      end
      CAPTURE: begin
        if (sample) begin
          samp_d = samp_q + 8'd1;
          if (f2 && f2cnt_q != CNT_MAX) f2cnt_d = f2cnt_q + CNT_W'(1);
          if (!push) ovf_d = 1'b1;
`ifdef RESULT_CAPTURE_EDGE_EN
          prev_d = f2;
          if (f2 && !prev_q && edge_q != CNT_MAX) edge_d = edge_q + CNT_W'(1);
`endif
          if (samp_q == LAST_SAMP) state_d = DRAIN;
        end
      end
      // A pop that takes the last entry counts as empty on this edge.
      DRAIN: begin
        if (empty || (pop && count == (AW + 1)'(1))) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      samp_q  <= '0;
      f2cnt_q <= '0;
      ovf_q   <= 1'b0;
`ifdef RESULT_CAPTURE_EDGE_EN
      prev_q  <= 1'b0;
      edge_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      samp_q  <= samp_d;
      f2cnt_q <= f2cnt_d;
      ovf_q   <= ovf_d;
`ifdef RESULT_CAPTURE_EDGE_EN
      prev_q  <= prev_d;
      edge_q  <= edge_d;
`endif
    end
  end

  assign out_valid = !empty;
  assign out_data  = out_valid ? head : 2'b00;
  assign busy      = (state_q == CAPTURE) || (state_q == DRAIN);
  assign done      = (state_q == DONE);
  assign f2_count  = f2cnt_q;
  assign overflow  = ovf_q;
`ifdef RESULT_CAPTURE_EDGE_EN
  assign edge_count = edge_q;
`endif

endmodule

// File: tb/tb_result_capture.sv
// Self-checking bench for result_capture: a queue-based reference model predicts pops and statistics.
// Edge-count checks are compiled in when RESULT_CAPTURE_EDGE_EN is defined.
module tb_result_capture;

  localparam int MDEPTH = 8;
  localparam int MNSAMP = 16;

  logic       clk = 1'b0;
  logic       rst_n, start, in_valid, f1, f2, out_ready;
  logic       out_valid, busy, done, overflow;
  logic [1:0] out_data;
  logic [7:0] f2_count;
  logic       sOutValid, sBusy, sDone, sOverflow;
  logic [1:0] sOutData, sF2Count;
`ifdef RESULT_CAPTURE_EDGE_EN
  logic [7:0] edge_count;
  logic [1:0] sEdgeCount;
`endif

  int checks = 0;
  int failures = 0;

  // Reference model: run phase, FIFO contents and statistics.
  int         mPhase;
  int         mTaken;
  int         mF2;
  int         mEdge;
  bit         mOvf;
  bit         mPrev;
  logic [1:0] mq[$];
  logic [1:0] dutPops[$];
  logic [1:0] expPops[$];
  int         doneSeen;

  always #5 clk = ~clk;

  result_capture dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .f1        (f1),
    .f2        (f2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done),
    .f2_count  (f2_count),
    .overflow  (overflow)
`ifdef RESULT_CAPTURE_EDGE_EN
    ,
    .edge_count(edge_count)
`endif
  );

  result_capture #(
    .DEPTH(8),
    .NSAMP(8),
    .CNT_W(2)
  ) dutSmall (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .f1        (f1),
    .f2        (f2),
    .out_valid (sOutValid),
    .out_ready (out_ready),
    .out_data  (sOutData),
    .busy      (sBusy),
    .done      (sDone),
    .f2_count  (sF2Count),
    .overflow  (sOverflow)
`ifdef RESULT_CAPTURE_EDGE_EN
    ,
    .edge_count(sEdgeCount)
`endif
  );

  task automatic resetModel();
    mPhase = 0;
    mTaken = 0;
    mF2 = 0;
    mEdge = 0;
    mOvf = 0;
    mPrev = 0;
    mq.delete();
  endtask

  task automatic clearLogs();
    dutPops.delete();
    expPops.delete();
    doneSeen = 0;
  endtask

  // Drive one cycle, record what the DUT pops, and advance the model by the same cycle.
  task automatic tick(input bit st, input bit iv, input bit a, input bit b, input bit rdy);
    bit pop;
    bit push;
    int ph;
    start = st;
    in_valid = iv;
    f1 = a;
    f2 = b;
    out_ready = rdy;
    @(negedge clk);
    if (out_valid === 1'b1 && rdy) dutPops.push_back(out_data);
    if (done === 1'b1) doneSeen++;
    ph = mPhase;
    pop = (mq.size() > 0) && rdy;
    push = 0;
    case (ph)
      0: if (st) begin
        mPhase = 1;
        mTaken = 0;
        mF2 = 0;
        mEdge = 0;
        mOvf = 0;
        mPrev = 0;
      end
      1: if (iv) begin
        mTaken++;
        if (b) mF2 = (mF2 < 255) ? mF2 + 1 : 255;
        if (b && !mPrev) mEdge = (mEdge < 255) ? mEdge + 1 : 255;
        mPrev = b;
        if (mq.size() < MDEPTH || pop) push = 1;
        else mOvf = 1;
        if (mTaken == MNSAMP) mPhase = 2;
      end
      3: mPhase = 0;
      default: ;
    endcase
    if (pop) expPops.push_back(mq.pop_front());
    if (push) mq.push_back({a, b});
    if (ph == 2 && mq.size() == 0) mPhase = 3;
    @(posedge clk);
    #1;
  endtask

  task automatic finish_run();
    int c = 0;
    while ((busy === 1'b1 || done === 1'b1 || mPhase != 0) && c < 300) begin
      tick(0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0);
      c++;
    end
    checks++;
    if (busy !== 1'b0 || c >= 300) begin
      failures++;
      $display("[TB] FAIL run_end_timeout: busy=%b cycles=%0d required busy=0 within 300", busy, c);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 0;
    in_valid = 0;
    f1 = 0;
    f2 = 0;
    out_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, busy, done, overflow, out_data} !== 6'b0) begin
      failures++;
      $display("[TB] FAIL reset_flags: got valid/busy/done/ovf/data=%b required 000000",
               {out_valid, busy, done, overflow, out_data});
    end
    checks++;
    if (f2_count !== 8'd0) begin
      failures++;
      $display("[TB] FAIL reset_f2_count: got %0d required 0", f2_count);
    end
    rst_n = 1'b1;
    resetModel();
  endtask

  task automatic test_alternating();
    int bad = 0;
    clearLogs();
    tick(1, 0, 0, 0, 1);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL alt_busy_after_start: got %b required 1", busy);
    end
    for (int i = 0; i < 16; i++) tick(0, 1, 1, (i % 2) == 0, 1);
    finish_run();
    foreach (expPops[i]) if (i >= dutPops.size() || dutPops[i] !== expPops[i]) bad++;
    checks++;
    if (dutPops.size() != 16 || bad != 0) begin
      failures++;
      $display("[TB] FAIL alt_pops: got %0d pops (%0d wrong) required 16 in order", dutPops.size(), bad);
    end
    checks++;
    if (f2_count !== 8'd8 || overflow !== 1'b0) begin
      failures++;
      $display("[TB] FAIL alt_stats: got f2_count=%0d overflow=%b required 8/0", f2_count, overflow);
    end
    checks++;
    if (doneSeen != 1) begin
      failures++;
      $display("[TB] FAIL alt_done_pulses: got %0d required 1", doneSeen);
    end
  endtask

  task automatic test_overflow();
    int bad = 0;
    clearLogs();
    tick(1, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++)
      tick(0, 1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 0);
    checks++;
    if (overflow !== 1'b1 || out_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL ovf_flag: got overflow=%b out_valid=%b required 1/1", overflow, out_valid);
    end
    checks++;
    if (f2_count !== 8'(mF2)) begin
      failures++;
      $display("[TB] FAIL ovf_f2_count: got %0d required %0d", f2_count, mF2);
    end
    finish_run();
    foreach (expPops[i]) if (i >= dutPops.size() || dutPops[i] !== expPops[i]) bad++;
    checks++;
    if (dutPops.size() != 8 || bad != 0 || doneSeen != 1) begin
      failures++;
      $display("[TB] FAIL ovf_drain: got %0d pops (%0d wrong) %0d done required 8 pops 1 done",
               dutPops.size(), bad, doneSeen);
    end
  endtask

  task automatic test_full_pop();
    int bad = 0;
    clearLogs();
    tick(1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) tick(0, 1, $urandom_range(0, 1) == 1, 1, 0);
    tick(0, 1, 1, 0, 1);
    checks++;
    if (overflow !== 1'b0 || out_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL full_pop_write: got overflow=%b out_valid=%b required 0/1", overflow, out_valid);
    end
    for (int i = 0; i < 7; i++) tick(0, 1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 1);
    finish_run();
    foreach (expPops[i]) if (i >= dutPops.size() || dutPops[i] !== expPops[i]) bad++;
    checks++;
    if (dutPops.size() != 16 || bad != 0 || overflow !== 1'b0) begin
      failures++;
      $display("[TB] FAIL full_pop_stream: got %0d pops (%0d wrong) overflow=%b required 16/0/0",
               dutPops.size(), bad, overflow);
    end
  endtask

  task automatic test_reset_midrun();
    clearLogs();
    tick(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) tick(0, 1, 1, 1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, busy, done, overflow, out_data} !== 6'b0 || f2_count !== 8'd0) begin
      failures++;
      $display("[TB] FAIL midrun_reset: got valid/busy/done/ovf/data=%b f2_count=%0d required all 0",
               {out_valid, busy, done, overflow, out_data}, f2_count);
    end
`ifdef RESULT_CAPTURE_EDGE_EN
    checks++;
    if (edge_count !== 8'd0) begin
      failures++;
      $display("[TB] FAIL midrun_reset_edge: got %0d required 0", edge_count);
    end
`endif
    resetModel();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_edge();
    bit pat[8] = '{0, 1, 1, 0, 1, 0, 1, 1};
    int bad = 0;
    clearLogs();
    tick(1, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) tick(i % 3 == 1, 1, 0, pat[i], $urandom_range(0, 1) == 1);
    checks++;
    if (f2_count !== 8'd5 || busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL edge_f2_count: got %0d busy=%b required 5/1", f2_count, busy);
    end
`ifdef RESULT_CAPTURE_EDGE_EN
    checks++;
    if (edge_count !== 8'd3) begin
      failures++;
      $display("[TB] FAIL edge_count_pattern: got %0d required 3", edge_count);
    end
`endif
    for (int i = 0; i < 8; i++) tick(1, 1, 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
    finish_run();
    foreach (expPops[i]) if (i >= dutPops.size() || dutPops[i] !== expPops[i]) bad++;
    checks++;
    if (dutPops.size() != expPops.size() || bad != 0 || f2_count !== 8'(mF2)) begin
      failures++;
      $display("[TB] FAIL edge_run: got %0d pops (%0d wrong) f2_count=%0d required %0d pops f2_count=%0d",
               dutPops.size(), bad, f2_count, expPops.size(), mF2);
    end
`ifdef RESULT_CAPTURE_EDGE_EN
    checks++;
    if (edge_count !== 8'(mEdge)) begin
      failures++;
      $display("[TB] FAIL edge_count_run: got %0d required %0d", edge_count, mEdge);
    end
`endif
  endtask

  task automatic test_saturation();
    int expSmall;
    clearLogs();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    resetModel();
    tick(1, 0, 0, 0, 1);
    for (int k = 1; k <= 16; k++) begin
      tick(0, 1, $urandom_range(0, 1) == 1, 1, 1);
      expSmall = (k < 3) ? k : 3;
      if (k == 2 || k == 8 || k == 16) begin
        checks++;
        if (sF2Count !== 2'(expSmall)) begin
          failures++;
          $display("[TB] FAIL sat_f2_count_k%0d: got %0d required %0d", k, sF2Count, expSmall);
        end
      end
    end
    finish_run();
    checks++;
    if (f2_count !== 8'd16 || sF2Count !== 2'd3 || sOverflow !== 1'b0) begin
      failures++;
      $display("[TB] FAIL sat_final: got f2_count=%0d small=%0d small_ovf=%b required 16/3/0",
               f2_count, sF2Count, sOverflow);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      int bad = 0;
      clearLogs();
      tick(1, 0, 0, 0, $urandom_range(0, 1) == 1);
      while (mPhase == 1) begin
        tick($urandom_range(0, 3) == 0, $urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
             $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      end
      finish_run();
      foreach (expPops[i]) if (i >= dutPops.size() || dutPops[i] !== expPops[i]) bad++;
      checks++;
      if (dutPops.size() != expPops.size() || bad != 0) begin
        failures++;
        $display("[TB] FAIL rand%0d_pops: got %0d pops (%0d wrong) required %0d",
                 r, dutPops.size(), bad, expPops.size());
      end
      checks++;
      if (f2_count !== 8'(mF2) || overflow !== mOvf || doneSeen != 1) begin
        failures++;
        $display("[TB] FAIL rand%0d_stats: got f2=%0d ovf=%b done=%0d required f2=%0d ovf=%b done=1",
                 r, f2_count, overflow, doneSeen, mF2, mOvf);
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    resetModel();
    clearLogs();
    test_reset();
    test_alternating();
    test_overflow();
    test_full_pop();
    test_reset_midrun();
    test_random();
    test_edge();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
